cdc_tx_scheduler: RTL and testbench

Source-domain scheduler that shares one bus-synchronizer crossing between several requesters. It arbitrates requesters round-robin and launches one word at a time. For each word it drives a stable bus plus a level enable for a fixed number of cycles, then keeps the bus stable through a guard gap so the destination-domain synchronizer captures it exactly once. It sits in the source clock domain, directly in front of the destination's multi-flop data synchronizer.

---
 rtl/cdc_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_cdc_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_tx_scheduler.sv
// cdc_tx_scheduler
//
// Source-domain scheduler that shares one bus-synchronizer crossing between
// several requesters. Requesters are arbitrated round-robin. Each granted word
// is launched on a stable bus with a level enable held for HOLD_CYCLES. The bus
// is then kept stable, with the enable low, for GAP_CYCLES. This lets the
// destination synchronizer capture every word exactly once.
//
// Ports:
//   CLK         source-domain clock, rising edge
//   RST         synchronous active-high reset
//   req         per-requester word-valid, held by the requester until granted
//   req_data    requester i's word at bits [i*BUS_WIDTH +: BUS_WIDTH]
//   grant       one-hot accept strobe, combinational, only asserted in IDLE
//   busy        high whenever a word is in flight (HOLD or GAP)
//   unsync_bus  registered word presented to the destination synchronizer
//   bus_enable  registered level enable presented to the synchronizer
//   xfer_done   registered one-cycle pulse after each completed word

module cdc_tx_scheduler #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic                         xfer_done
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned LAST_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LAST_W-1:0] LAST_RST  = LAST_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [LAST_W-1:0]   last;

    logic [LAST_W-1:0]   sel;
    logic                found;
    logic [LAST_W-1:0]   cand;
    logic [BUS_WIDTH-1:0] sel_word;

    // Round-robin search starting one past the last winner, so the most recently
    // granted requester is considered last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned j = 1; j <= NUM_REQ; j++) begin
            cand = LAST_W'((32'(last) + j) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Word mux for the selected requester.
    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (LAST_W'(i) == sel) begin
                sel_word = req_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Grant is suppressed during reset so a requester never sees an accept
    // for a word the scheduler is about to discard.
    always_comb begin
        grant = '0;
        if (state == StIdle && !RST && found) begin
            grant[sel] = 1'b1;
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            cnt        <= '0;
            last       <= LAST_RST;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            xfer_done  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // The bus only ever changes on this edge.
                    if (found) begin
                        unsync_bus <= sel_word;
                        bus_enable <= 1'b1;
                        last       <= sel;
                        cnt        <= HOLD_LOAD;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    if (cnt == '0) begin
                        bus_enable <= 1'b0;
                        cnt        <= GAP_LOAD;
                        state      <= StGap;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == '0) begin
                        xfer_done <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    bus_enable <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Bench for cdc_tx_scheduler: three instances (defaults; HOLD=GAP=1; four
// requesters with HOLD=3, GAP=2) share clock and reset. A timeline model
// predicts every output each cycle from the cycle of the last grant.
module tb_cdc_tx_scheduler;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [3:0]  req_v  [3];
    logic [31:0] data_v [3];

    logic [1:0] g0, g1;
    logic [3:0] g2;
    logic       b0, b1, b2, e0, e1, e2, d0, d1, d2;
    logic [7:0] u0, u1, u2;

    cdc_tx_scheduler #(.BUS_WIDTH(8), .NUM_REQ(2), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut0 (
        .CLK(CLK), .RST(RST), .req(req_v[0][1:0]), .req_data(data_v[0][15:0]),
        .grant(g0), .busy(b0), .unsync_bus(u0), .bus_enable(e0), .xfer_done(d0)
    );
    cdc_tx_scheduler #(.BUS_WIDTH(8), .NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .req(req_v[1][1:0]), .req_data(data_v[1][15:0]),
        .grant(g1), .busy(b1), .unsync_bus(u1), .bus_enable(e1), .xfer_done(d1)
    );
    cdc_tx_scheduler #(.BUS_WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut2 (
        .CLK(CLK), .RST(RST), .req(req_v[2]), .req_data(data_v[2]),
        .grant(g2), .busy(b2), .unsync_bus(u2), .bus_enable(e2), .xfer_done(d2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic rst_s  = 1'b1;

    int nk [3] = '{2, 2, 4};
    int hk [3] = '{4, 1, 3};
    int gk [3] = '{4, 1, 2};

    // Requesters: pending flag plus word. refill 0 = one-shot, 1 = re-request
    // the same word forever, 2 = random new requests.
    logic       pend [3][4];
    logic [7:0] wd   [3][4];
    int         refill [3];

    // Model: cycle of the last accepted grant (-1 = none since reset), the word
    // on the bus and the last winner.
    int         tg [3];
    logic [7:0] mw [3];
    int         ml [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] ga [3];
        logic [7:0] ua [3];
        logic       ba [3];
        logic       ea [3];
        logic       da [3];
        @(posedge CLK);
        #1;
        RST = rst_s;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nk[k]; i++) begin
                if (refill[k] == 2 && !pend[k][i] && $urandom_range(2) == 0) begin
                    pend[k][i] = 1'b1;
                    wd[k][i]   = 8'($urandom);
                end
                req_v[k][i]         = pend[k][i];
                data_v[k][i*8 +: 8] = wd[k][i];
            end
        end
        @(negedge CLK);
        ga[0] = {2'b00, g0}; ga[1] = {2'b00, g1}; ga[2] = g2;
        ua[0] = u0; ua[1] = u1; ua[2] = u2;
        ba[0] = b0; ba[1] = b1; ba[2] = b2;
        ea[0] = e0; ea[1] = e1; ea[2] = e2;
        da[0] = d0; da[1] = d1; da[2] = d2;
        for (int k = 0; k < 3; k++) begin
            int       d;
            int       sel;
            int       idx;
            bit       idle;
            logic [3:0] eg;
            d    = cyc - tg[k];
            idle = (tg[k] < 0) || (d >= hk[k] + gk[k] + 1);
            sel  = -1;
            eg   = '0;
            if (idle && !rst_s) begin
                for (int j = 1; j <= nk[k]; j++) begin
                    idx = (ml[k] + j) % nk[k];
                    if (sel < 0 && req_v[k][idx]) sel = idx;
                end
            end
            if (sel >= 0) eg[sel] = 1'b1;
            chk("grant", k, 32'(ga[k]), 32'(eg));
            chk("busy", k, 32'(ba[k]), 32'(!idle));
            chk("bus_enable", k, 32'(ea[k]), 32'(!idle && d <= hk[k]));
            chk("xfer_done", k, 32'(da[k]), 32'(tg[k] >= 0 && d == hk[k] + gk[k] + 1));
            chk("unsync_bus", k, 32'(ua[k]), 32'(mw[k]));
            if (rst_s) begin
                tg[k] = -1;
                mw[k] = 8'h00;
                ml[k] = nk[k] - 1;
            end else if (sel >= 0) begin
                tg[k] = cyc;
                mw[k] = wd[k][sel];
                ml[k] = sel;
                if (refill[k] != 1) pend[k][sel] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 3; k++) begin
            refill[k] = 0;
            for (int i = 0; i < 4; i++) pend[k][i] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_v[k]  = '0;
            data_v[k] = '0;
            tg[k]     = -1;
            mw[k]     = 8'h00;
            ml[k]     = nk[k] - 1;
            refill[k] = 0;
            for (int i = 0; i < 4; i++) begin
                pend[k][i] = 1'b0;
                wd[k][i]   = 8'h00;
            end
        end

        // Reset state
        step();
        chk("rst_en", 0, 32'(e0), 32'd0);
        chk("rst_bus", 0, 32'(u0), 32'd0);
        rst_s = 1'b0;
        step();

        // Single word A5 from requester 0
        wd[0][0] = 8'hA5; pend[0][0] = 1'b1;
        step();
        chk("a_grant", 0, 32'(g0), 32'h1);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("a_hold_bus", 0, 32'(u0), 32'hA5);
            chk("a_hold_en", 0, 32'(e0), 32'h1);
        end
        for (int j = 5; j <= 8; j++) begin
            step();
            chk("a_gap_bus", 0, 32'(u0), 32'hA5);
            chk("a_gap_en", 0, 32'(e0), 32'h0);
        end
        step();
        chk("a_done", 0, 32'(d0), 32'h1);

        // Both held high: alternation 01,10,01,10 every 9 cycles
        do_reset();
        wd[0][0] = 8'h11; wd[0][1] = 8'h22;
        pend[0][0] = 1'b1; pend[0][1] = 1'b1; refill[0] = 1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("b_grant", 0, 32'(g0), (n % 2 == 1) ? 32'h2 : 32'h1);
            step();
            chk("b_bus", 0, 32'(u0), (n % 2 == 1) ? 32'h22 : 32'h11);
            repeat (7) step();
        end
        clear_reqs();
        repeat (10) step();

        // Requester 1 arrives during HOLD of requester 0's word
        wd[0][0] = 8'h33; pend[0][0] = 1'b1;
        step();
        chk("c_grant0", 0, 32'(g0), 32'h1);
        step();
        wd[0][1] = 8'h44; pend[0][1] = 1'b1;
        for (int j = 2; j <= 8; j++) begin
            step();
            chk("c_no_grant", 0, 32'(g0), 32'h0);
            chk("c_bus_stable", 0, 32'(u0), 32'h33);
        end
        step();
        chk("c_grant1", 0, 32'(g0), 32'h2);
        chk("c_done", 0, 32'(d0), 32'h1);
        repeat (10) step();

        // Reset at T+2 aborts the word
        wd[0][0] = 8'h55; wd[0][1] = 8'h66;
        pend[0][0] = 1'b1; pend[0][1] = 1'b1;
        step();
        chk("d_grant", 0, 32'(g0), 32'h1);
        step();
        rst_s = 1'b1;
        step();
        chk("d_grant_in_rst", 0, 32'(g0), 32'h0);
        rst_s = 1'b0;
        wd[0][0] = 8'h77; pend[0][0] = 1'b1;
        step();
        chk("d_en", 0, 32'(e0), 32'h0);
        chk("d_bus", 0, 32'(u0), 32'h0);
        chk("d_busy", 0, 32'(b0), 32'h0);
        chk("d_done", 0, 32'(d0), 32'h0);
        chk("d_regrant", 0, 32'(g0), 32'h1);
        clear_reqs();
        repeat (10) step();

        // HOLD=GAP=1: period of 3
        do_reset();
        wd[1][0] = 8'h5A; pend[1][0] = 1'b1; refill[1] = 1;
        for (int n = 0; n < 9; n++) begin
            step();
            chk("e_en", 1, 32'(e1), 32'(n % 3 == 1));
            chk("e_done", 1, 32'(d1), 32'(n > 0 && n % 3 == 0));
        end
        clear_reqs();
        repeat (4) step();

        // Four requesters, req=1010 after requester 3 last: 1,3,1
        do_reset();
        wd[2][1] = 8'hC1; wd[2][3] = 8'hC3;
        pend[2][1] = 1'b1; pend[2][3] = 1'b1; refill[2] = 1;
        for (int r = 0; r < 3; r++) begin
            step();
            chk("f_grant", 2, 32'(g2), (r == 1) ? 32'h8 : 32'h2);
            repeat (5) step();
        end
        clear_reqs();
        repeat (10) step();

        // Random traffic with occasional reset
        for (int k = 0; k < 3; k++) refill[k] = 2;
        for (int n = 0; n < 3000; n++) begin
            rst_s = ($urandom_range(199) == 0);
            step();
        end
        rst_s = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
